// File: rtl/sram_sp_be_ctrl.sv
// Single-port bit-enable SRAM initiator: write/read arbitration, in-flight read tracking,
// credit-protected response FIFO and a sticky read-return protocol check.
module sram_sp_be_ctrl #(
    parameter int unsigned KNOB_REGOUT = 0,
    parameter int unsigned SIZE        = 32,
    parameter int unsigned SIZE_COL    = 8,
    parameter int unsigned DATA_WD     = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    localparam int unsigned SIZE_WD    = $clog2(SIZE),
    localparam int unsigned MSK_WD     = DATA_WD / SIZE_COL
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               wr_req_val_i,
    output logic               wr_req_rdy_o,
    input  logic [SIZE_WD-1:0] wr_req_adr_i,
    input  logic [MSK_WD-1:0]  wr_req_msk_i,
    input  logic [DATA_WD-1:0] wr_req_dat_i,
    input  logic               rd_req_val_i,
    output logic               rd_req_rdy_o,
    input  logic [SIZE_WD-1:0] rd_req_adr_i,
    output logic               rd_rsp_val_o,
    input  logic               rd_rsp_rdy_i,
    output logic [DATA_WD-1:0] rd_rsp_dat_o,
    output logic [SIZE_WD-1:0] sram_adr_o,
    output logic [MSK_WD-1:0]  sram_wr_val_o,
    output logic [DATA_WD-1:0] sram_wr_dat_o,
    output logic               sram_rd_val_o,
    input  logic               sram_rd_val_i,
    input  logic [DATA_WD-1:0] sram_rd_dat_i,
    output logic               err_o
);

    localparam int unsigned LAT    = 1 + KNOB_REGOUT;
    localparam int unsigned PTR_WD = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_WD = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_WD = CNT_WD + 1;

    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_e;

    prio_e              prio_q, prio_d;
    logic               rd_ok, rd_elig, wr_gnt, rd_gnt;
    logic [CNT_WD-1:0]  inflight_q, fifo_cnt_q;
    logic [PTR_WD-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LAT-1:0]     exp_q;
    logic [DATA_WD-1:0] mem [FIFO_DEPTH];
    logic               empty, full, push, pop, drop, ret_dec;

    // Credit excludes the same-cycle pop so rd_rsp_rdy_i never reaches rd_req_rdy_o.
    assign rd_ok   = (SUM_WD'(inflight_q) + SUM_WD'(fifo_cnt_q)) < SUM_WD'(FIFO_DEPTH);
    assign rd_elig = rd_req_val_i & rd_ok;

    // Arbitration: priority only consulted and flipped when both sides are eligible.
    always_comb begin
        prio_d = prio_q;
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (wr_req_val_i && rd_elig) begin
            if (prio_q == PRIO_WR) begin
                wr_gnt = 1'b1;
                prio_d = PRIO_RD;
            end else begin
                rd_gnt = 1'b1;
                prio_d = PRIO_WR;
            end
        end else begin
            wr_gnt = wr_req_val_i;
            rd_gnt = rd_elig;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) prio_q <= PRIO_WR;
        else       prio_q <= prio_d;
    end

    assign wr_req_rdy_o = wr_gnt;
    assign rd_req_rdy_o = rd_gnt;

    always_comb begin
        sram_adr_o    = '0;
        sram_wr_val_o = '0;
        sram_wr_dat_o = '0;
        sram_rd_val_o = 1'b0;
        if (wr_gnt) begin
            sram_adr_o    = wr_req_adr_i;
            sram_wr_val_o = wr_req_msk_i;
            sram_wr_dat_o = wr_req_dat_i;
        end else if (rd_gnt) begin
            sram_adr_o    = rd_req_adr_i;
            sram_rd_val_o = 1'b1;
        end
    end

    assign empty   = (fifo_cnt_q == '0);
    assign full    = (fifo_cnt_q == CNT_WD'(FIFO_DEPTH));
    assign pop     = ~empty & rd_rsp_rdy_i;
    assign push    = sram_rd_val_i & (~full | pop);
    assign drop    = sram_rd_val_i & full & ~pop;
    assign ret_dec = sram_rd_val_i & (inflight_q != '0);

    assign rd_rsp_val_o = ~empty;
    assign rd_rsp_dat_o = empty ? '0 : mem[rd_ptr_q];

    // Response storage is data-only and intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= sram_rd_dat_i;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            inflight_q <= '0;
            exp_q      <= '0;
            err_o      <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_WD'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_WD'(1);
            if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + CNT_WD'(1);
            else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - CNT_WD'(1);
            if (rd_gnt && !ret_dec)      inflight_q <= inflight_q + CNT_WD'(1);
            else if (ret_dec && !rd_gnt) inflight_q <= inflight_q - CNT_WD'(1);
            // Grant history predicts exactly when sram_rd_val_i must fire.
            exp_q <= LAT'({exp_q, rd_gnt});
            if (drop || (sram_rd_val_i != exp_q[LAT-1])) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_sp_be_ctrl.sv
// Self-checking bench for sram_sp_be_ctrl with a behavioural bit-enable SRAM and
// an in-order read-response scoreboard.
module tb_sram_sp_be_ctrl;

    localparam int unsigned KNOB_REGOUT = 0;
    localparam int unsigned LAT         = 1 + KNOB_REGOUT;
    localparam int unsigned SIZE        = 32;
    localparam int unsigned SIZE_WD     = 5;
    localparam int unsigned SIZE_COL    = 8;
    localparam int unsigned DATA_WD     = 32;
    localparam int unsigned MSK_WD      = 4;
    localparam int unsigned FIFO_DEPTH  = 4;

    logic               clk, rstn;
    logic               wr_req_val_i, wr_req_rdy_o;
    logic [SIZE_WD-1:0] wr_req_adr_i;
    logic [MSK_WD-1:0]  wr_req_msk_i;
    logic [DATA_WD-1:0] wr_req_dat_i;
    logic               rd_req_val_i, rd_req_rdy_o;
    logic [SIZE_WD-1:0] rd_req_adr_i;
    logic               rd_rsp_val_o, rd_rsp_rdy_i;
    logic [DATA_WD-1:0] rd_rsp_dat_o;
    logic [SIZE_WD-1:0] sram_adr_o;
    logic [MSK_WD-1:0]  sram_wr_val_o;
    logic [DATA_WD-1:0] sram_wr_dat_o;
    logic               sram_rd_val_o, sram_rd_val_i;
    logic [DATA_WD-1:0] sram_rd_dat_i;
    logic               err_o;

    logic               inject;
    int                 n_checks = 0;
    int                 n_fail   = 0;
    int                 n_rsp    = 0;
    logic [DATA_WD-1:0] last_rsp;
    logic [DATA_WD-1:0] exp_q [$];
    logic [DATA_WD-1:0] shadow [SIZE];
    logic [DATA_WD-1:0] sram_mem [SIZE];
    logic [1:0]         sv;
    logic [DATA_WD-1:0] sd1, sd2;

    sram_sp_be_ctrl #(
        .KNOB_REGOUT(KNOB_REGOUT), .SIZE(SIZE), .SIZE_COL(SIZE_COL),
        .DATA_WD(DATA_WD), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .wr_req_val_i(wr_req_val_i), .wr_req_rdy_o(wr_req_rdy_o),
        .wr_req_adr_i(wr_req_adr_i), .wr_req_msk_i(wr_req_msk_i), .wr_req_dat_i(wr_req_dat_i),
        .rd_req_val_i(rd_req_val_i), .rd_req_rdy_o(rd_req_rdy_o), .rd_req_adr_i(rd_req_adr_i),
        .rd_rsp_val_o(rd_rsp_val_o), .rd_rsp_rdy_i(rd_rsp_rdy_i), .rd_rsp_dat_o(rd_rsp_dat_o),
        .sram_adr_o(sram_adr_o), .sram_wr_val_o(sram_wr_val_o), .sram_wr_dat_o(sram_wr_dat_o),
        .sram_rd_val_o(sram_rd_val_o), .sram_rd_val_i(sram_rd_val_i), .sram_rd_dat_i(sram_rd_dat_i),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural SRAM: column-masked write, registered read of LAT cycles.
    always @(posedge clk) begin
        for (int c = 0; c < MSK_WD; c++)
            if (sram_wr_val_o[c])
                sram_mem[sram_adr_o][c*SIZE_COL +: SIZE_COL] <= sram_wr_dat_o[c*SIZE_COL +: SIZE_COL];
        sd1 <= sram_mem[sram_adr_o];
        sd2 <= sd1;
    end
    always @(posedge clk or negedge rstn) begin
        if (!rstn) sv <= 2'b00;
        else       sv <= {sv[0], sram_rd_val_o};
    end
    assign sram_rd_val_i = sv[LAT-1] | inject;
    assign sram_rd_dat_i = (LAT == 1) ? sd1 : sd2;

    // Monitor: model writes into shadow, queue read expectations, score responses.
    always @(negedge clk) begin
        if (rstn) begin
            check("single_grant", {wr_req_rdy_o, rd_req_rdy_o} == 2'b11, 0);
            if (wr_req_val_i && wr_req_rdy_o) begin
                check("sram_wr_adr", sram_adr_o, wr_req_adr_i);
                check("sram_wr_msk", sram_wr_val_o, wr_req_msk_i);
                check("sram_wr_dat", sram_wr_dat_o, wr_req_dat_i);
                check("sram_wr_nord", sram_rd_val_o, 0);
                for (int c = 0; c < MSK_WD; c++)
                    if (wr_req_msk_i[c])
                        shadow[wr_req_adr_i][c*SIZE_COL +: SIZE_COL] = wr_req_dat_i[c*SIZE_COL +: SIZE_COL];
            end
            if (rd_req_val_i && rd_req_rdy_o) begin
                check("sram_rd_adr", sram_adr_o, rd_req_adr_i);
                check("sram_rd_strobe", sram_rd_val_o, 1);
                check("sram_rd_nowr", sram_wr_val_o, 0);
                exp_q.push_back(shadow[rd_req_adr_i]);
            end
            if (rd_rsp_val_o && rd_rsp_rdy_i) begin
                n_rsp++;
                last_rsp = rd_rsp_dat_o;
                check("rsp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("rsp_data", rd_rsp_dat_o, exp_q.pop_front());
            end
        end
    end

    task automatic do_write(input logic [SIZE_WD-1:0] a, input logic [MSK_WD-1:0] m,
                            input logic [DATA_WD-1:0] d);
        bit ok = 0;
        wr_req_val_i = 1'b1; wr_req_adr_i = a; wr_req_msk_i = m; wr_req_dat_i = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_req_rdy_o) begin ok = 1; break; end
        end
        check("wr_accept", ok, 1);
        @(posedge clk); #1;
        wr_req_val_i = 1'b0;
    endtask

    task automatic do_read(input logic [SIZE_WD-1:0] a);
        bit ok = 0;
        rd_req_val_i = 1'b1; rd_req_adr_i = a;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_req_rdy_o) begin ok = 1; break; end
        end
        check("rd_accept", ok, 1);
        @(posedge clk); #1;
        rd_req_val_i = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (n_rsp >= target) begin ok = 1; break; end
        end
        check("rsp_arrival", ok, 1);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, wi, ri, acc;
        bit gw, gr;
        for (int i = 0; i < SIZE; i++) begin shadow[i] = '0; sram_mem[i] = '0; end
        rstn = 1'b0; inject = 1'b0; rd_rsp_rdy_i = 1'b1;
        wr_req_val_i = 1'b0; wr_req_adr_i = '0; wr_req_msk_i = '0; wr_req_dat_i = '0;
        rd_req_val_i = 1'b0; rd_req_adr_i = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Reset / idle state and combinational ready
        @(negedge clk);
        check("rst_rsp_val", rd_rsp_val_o, 0);
        check("rst_rsp_dat", rd_rsp_dat_o, 0);
        check("rst_err", err_o, 0);
        check("rst_sram_adr", sram_adr_o, 0);
        check("rst_sram_wr", sram_wr_val_o, 0);
        check("rst_sram_rd", sram_rd_val_o, 0);
        check("rst_wr_rdy", wr_req_rdy_o, 0);
        check("rst_rd_rdy", rd_req_rdy_o, 0);
        wr_req_val_i = 1'b1; #1;
        check("idle_wr_rdy", wr_req_rdy_o, 1);
        wr_req_val_i = 1'b0; rd_req_val_i = 1'b1; #1;
        check("idle_rd_rdy", rd_req_rdy_o, 1);
        check("idle_rd_wr_rdy", wr_req_rdy_o, 0);
        rd_req_val_i = 1'b0;
        @(posedge clk); #1;

        // Both requesters valid for 8 cycles: strict W,R,W,R alternation
        n0 = n_rsp; wi = 0; ri = 0;
        for (int i = 0; i < 8; i++) begin
            wr_req_val_i = 1'b1; wr_req_msk_i = 4'hF;
            wr_req_adr_i = SIZE_WD'(8 + wi); wr_req_dat_i = 32'hC0DE_0000 + DATA_WD'(wi);
            rd_req_val_i = 1'b1; rd_req_adr_i = SIZE_WD'(8 + ri);
            @(negedge clk);
            check($sformatf("alt_wr%0d", i), wr_req_rdy_o, (i % 2 == 0));
            check($sformatf("alt_rd%0d", i), rd_req_rdy_o, (i % 2 == 1));
            gw = wr_req_rdy_o; gr = rd_req_rdy_o;
            @(posedge clk); #1;
            if (gw) wi++;
            if (gr) ri++;
        end
        wr_req_val_i = 1'b0; rd_req_val_i = 1'b0;
        wait_rsp(n0 + 4);
        repeat (3) @(posedge clk); #1;
        check("alt_rsp_cnt", n_rsp - n0, 4);

        // Full write then read with exact latency
        do_write(5'd5, 4'hF, 32'hA5A5_5A5A);
        do_read(5'd5);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check("lat_early", rd_rsp_val_o, 0);
        end
        @(negedge clk);
        check("lat_val", rd_rsp_val_o, 1);
        check("lat_dat", rd_rsp_dat_o, 32'hA5A5_5A5A);
        @(posedge clk); #1;

        // Column-masked write and all-zero-mask write
        do_write(5'd3, 4'hF, 32'hFFFF_FFFF);
        do_write(5'd3, 4'b0101, 32'h1122_3344);
        n0 = n_rsp;
        do_read(5'd3);
        wait_rsp(n0 + 1);
        check("partial_rd", last_rsp, 32'hFF22_FF44);
        do_write(5'd3, 4'b0000, 32'hDEAD_BEEF);
        n0 = n_rsp;
        do_read(5'd3);
        wait_rsp(n0 + 1);
        check("zero_msk_rd", last_rsp, 32'hFF22_FF44);

        // Backpressure: credits cap accepted reads at FIFO_DEPTH
        rd_rsp_rdy_i = 1'b0; n0 = n_rsp; acc = 0;
        rd_req_val_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd_req_adr_i = SIZE_WD'(8 + acc);
            @(negedge clk);
            gr = rd_req_rdy_o;
            @(posedge clk); #1;
            if (gr) acc++;
        end
        check("bp_accepted", acc, FIFO_DEPTH);
        rd_req_adr_i = 5'd12;
        @(negedge clk);
        check("bp_rd_stalled", rd_req_rdy_o, 0);
        check("bp_rsp_held", rd_rsp_val_o, 1);
        @(posedge clk); #1;
        do_write(5'd20, 4'hF, 32'h2020_2020);
        rd_req_val_i = 1'b0;
        check("bp_no_pop", n_rsp - n0, 0);
        rd_rsp_rdy_i = 1'b1;
        wait_rsp(n0 + FIFO_DEPTH);
        n0 = n_rsp;
        do_read(5'd20);
        wait_rsp(n0 + 1);
        check("bp_resume_dat", last_rsp, 32'h2020_2020);
        check("bp_err", err_o, 0);

        // Asynchronous reset with reads in flight
        rd_req_val_i = 1'b1; rd_req_adr_i = 5'd8;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd_req_val_i = 1'b0;
        #1 rstn = 1'b0;
        #1;
        n0 = n_rsp;
        check("arst_rsp_val", rd_rsp_val_o, 0);
        check("arst_rsp_dat", rd_rsp_dat_o, 0);
        check("arst_err", err_o, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (6) @(posedge clk); #1;
        check("arst_no_stale", n_rsp - n0, 0);
        check("arst_rsp_val_after", rd_rsp_val_o, 0);
        check("arst_err_after", err_o, 0);

        // Spurious read-valid sets sticky error
        rd_rsp_rdy_i = 1'b0;
        inject = 1'b1;
        @(posedge clk); #1;
        inject = 1'b0;
        @(negedge clk);
        check("spur_err", err_o, 1);
        repeat (5) @(negedge clk);
        check("spur_err_sticky", err_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_sp_be_ctrl.md
Name: sram_sp_be_ctrl

Overview:
Initiator/controller for a single-port, bit-enable, register-based SRAM with 1- or 2-cycle registered read latency. It arbitrates independent write-request and read-request valid/ready streams onto the SRAM's single address port, one access per cycle. It tracks in-flight reads and buffers returned data in a response FIFO with credit-based backpressure. It sits between datapath engines and a local scratch SRAM instance.

Parameters:
KNOB_REGOUT, 0, must match the attached SRAM; SRAM read latency LAT = 1 + KNOB_REGOUT cycles
SIZE, 32, SRAM depth in words; SIZE_WD = FUNC_LOG2(SIZE)
SIZE_COL, 8, bits per write-enable column
DATA_WD, 32, word width; must be a multiple of SIZE_COL; MSK_WD = DATA_WD/SIZE_COL
FIFO_DEPTH, 4, response FIFO entries; must be >= LAT+1; power of two

Ports:
clk  in  1  clock
rstn  in  1  reset
wr_req_val_i  in  1  write request valid
wr_req_rdy_o  out  1  write request accepted this cycle
wr_req_adr_i  in  SIZE_WD  write address
wr_req_msk_i  in  MSK_WD  per-column write enable
wr_req_dat_i  in  DATA_WD  write data
rd_req_val_i  in  1  read request valid
rd_req_rdy_o  out  1  read request accepted this cycle
rd_req_adr_i  in  SIZE_WD  read address
rd_rsp_val_o  out  1  response FIFO not empty
rd_rsp_rdy_i  in  1  consumer pops response
rd_rsp_dat_o  out  DATA_WD  FIFO head data
sram_adr_o  out  SIZE_WD  SRAM address
sram_wr_val_o  out  MSK_WD  SRAM column write enables
sram_wr_dat_o  out  DATA_WD  SRAM write data
sram_rd_val_o  out  1  SRAM read strobe
sram_rd_val_i  in  1  SRAM read data valid
sram_rd_dat_i  in  DATA_WD  SRAM read data
err_o  out  1  sticky protocol error

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. All state clears: FIFO pointers/count = 0, inflight = 0, prio = WR, err_o = 0, expected-valid shift register = 0. Resulting outputs: rd_rsp_val_o = 0, rd_rsp_dat_o = 0 (FIFO storage is not reset; output is forced to 0 while empty).
- Credit: rd_ok = (inflight + fifo_cnt < FIFO_DEPTH). The same-cycle pop is not counted, so there is no combinational path from rd_rsp_rdy_i to rd_req_rdy_o.
- Arbitration (combinational, one grant per cycle):
  - rd_elig = rd_req_val_i & rd_ok; wr_elig = wr_req_val_i.
  - Only one eligible: it is granted.
  - Both eligible: prio decides; prio then flips to the other side at the clock edge.
  - prio changes only in cycles where both are eligible.
- rdy semantics: wr_req_rdy_o = write grant; rd_req_rdy_o = read grant. rdy may depend on the val inputs. Requesters hold val/payload stable until rdy.
- SRAM drive (combinational from the grant):
  - Write granted: sram_adr_o = wr_req_adr_i, sram_wr_val_o = wr_req_msk_i, sram_wr_dat_o = wr_req_dat_i, sram_rd_val_o = 0.
  - Read granted: sram_adr_o = rd_req_adr_i, sram_rd_val_o = 1, sram_wr_val_o = 0.
  - Idle: all SRAM outputs 0.
  - A write with an all-zero mask is accepted and consumes the slot; no SRAM bits change.
- Read pipeline:
  - inflight increments on a read grant and decrements on sram_rd_val_i. Both in the same cycle leaves it unchanged.
  - On sram_rd_val_i, sram_rd_dat_i is pushed into the FIFO.
  - Read-accept cycle T -> rd_rsp_val_o first high in cycle T+1+LAT (2 cycles for KNOB_REGOUT=0, 3 for 1). No bypass path.
- FIFO:
  - Pop when rd_rsp_val_o & rd_rsp_rdy_i.
  - Simultaneous push and pop is allowed in any state, including full (count unchanged).
  - Pointers wrap modulo FIFO_DEPTH.
  - The credit rule guarantees no push when full; a push when full anyway sets err_o and the data is dropped.
- Protocol check: an LAT-deep shift register of read grants predicts sram_rd_val_i. Any mismatch sets err_o, which stays set until reset.
- Throughput: with rd_rsp_rdy_i held at 1, back-to-back reads sustain 1 read/cycle.

Test Plan:
- Reset then idle -> all outputs 0; rdy_o follows val_i (rd_ok is true).
- KNOB_REGOUT=0: write adr 5, msk 4'b1111, dat 0xA5A5_5A5A; then read adr 5 at cycle T -> rd_rsp_val_o at T+2 with 0xA5A5_5A5A. Repeat with KNOB_REGOUT=1 -> response at T+3.
- Partial write adr 3, msk 4'b0101, dat 0x1122_3344 over old 0xFFFF_FFFF -> readback 0xFF22_FF44; an all-zero-mask write leaves the word unchanged.
- Both requests valid every cycle for 8 cycles from reset -> grants alternate W,R,W,R,...; all 4 reads return in order with the correct data.
- rd_rsp_rdy_i=0 with continuous reads, FIFO_DEPTH=4 -> exactly 4 reads accepted, rd_req_rdy_o then 0, writes still granted; raising rd_rsp_rdy_i drains 4 in order and reads resume; err_o stays 0.
- Assert rstn low with 2 reads in flight -> outputs clear asynchronously; after release there are no stale responses and err_o=0. Inject a spurious sram_rd_val_i -> err_o=1 and stays 1.
